// File: rtl/adrv9001_tx_stream_ctrl_if.sv
// 32-bit sample stream bundle shared by the upstream source and the serializer side.
// Valid/ready: a word transfers on a rising clk edge where tvalid and tready are both 1;
// the master holds tdata stable while tvalid is high and not yet accepted.
interface adrv9001_tx_stream_ctrl_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/adrv9001_tx_stream_ctrl.sv
// Transmit stream controller: primes a small sample FIFO, then feeds the serializer a
// continuous-valid stream (DMA, constant idle or ramp), substituting idle data on underflow.
module adrv9001_tx_stream_ctrl #(
    parameter int          FIFO_DEPTH  = 16,
    parameter int          PRIME_LEVEL = 8,
    parameter logic [31:0] IDLE_DATA   = 32'h00000000,
    parameter int          UFLOW_CNT_W = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [1:0]                      mode,
    adrv9001_tx_stream_ctrl_if.slave        s_axis,
    adrv9001_tx_stream_ctrl_if.master       m_axis,
    output logic                            active,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            underflow,
    output logic [UFLOW_CNT_W-1:0]          underflow_cnt,
    output logic [1:0]                      dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       mode_q;
    logic [31:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    level;
    logic [31:0]      tdata_q;
    logic [15:0]      ramp_q;

    logic             s_ready;
    logic             push;
    logic             pop;
    logic             flush;
    logic             prime_done;
    logic             load;
    logic             uflow_evt;
    logic [31:0]      next_word;
    logic [15:0]      ramp_next;

    // Ready comes from the registered level only, so a full FIFO refuses input even while popping.
    assign s_ready    = (state_q != ST_IDLE) && (level < LW'(FIFO_DEPTH));
    assign push       = s_axis.tvalid && s_ready && (mode_q == 2'd0);
    assign flush      = (state_q == ST_IDLE) || !enable;
    assign prime_done = (mode_q == 2'd0) ? (level >= LW'(PRIME_LEVEL)) : 1'b1;

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        pop       = 1'b0;
        uflow_evt = 1'b0;
        ramp_next = ramp_q;
        next_word = tdata_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_PRIME;
            end
            ST_PRIME: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (prime_done) begin
                    state_d   = ST_RUN;
                    load      = 1'b1;
                    ramp_next = 16'd0;
                    case (mode_q)
                        2'd0: begin
                            next_word = mem[rd_ptr];
                            pop       = 1'b1;
                        end
                        2'd2:    next_word = {ramp_next, ~ramp_next};
                        default: next_word = IDLE_DATA;
                    endcase
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (m_axis.tready) begin
                    load = 1'b1;
                    case (mode_q)
                        2'd0: begin
                            if (level != '0) begin
                                next_word = mem[rd_ptr];
                                pop       = 1'b1;
                            end else begin
                                next_word = IDLE_DATA;
                                uflow_evt = 1'b1;
                            end
                        end
                        2'd2: begin
                            ramp_next = ramp_q + 16'd1;
                            next_word = {ramp_next, ~ramp_next};
                        end
                        default: next_word = IDLE_DATA;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mode_q        <= 2'd0;
            tdata_q       <= 32'h0;
            ramp_q        <= 16'd0;
            underflow     <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            state_q   <= state_d;
            underflow <= uflow_evt;
            if (state_q == ST_IDLE && enable) begin
                mode_q        <= mode;
                underflow_cnt <= '0;
            end else if (uflow_evt && underflow_cnt != '1) begin
                underflow_cnt <= underflow_cnt + 1'b1;
            end
            if (load) begin
                tdata_q <= next_word;
                ramp_q  <= ramp_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= s_axis.tdata;
    end

    // Stopping discards everything buffered on the same edge the FSM returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = (state_q == ST_RUN);
    assign m_axis.tdata  = tdata_q;
    assign active        = (state_q == ST_RUN);
    assign fifo_level    = level;
    assign dbg_state     = state_q;

endmodule

// File: doc/adrv9001_tx_stream_ctrl.md
# adrv9001_tx_stream_ctrl

Transmit sample-stream controller between the DMA/AXI-Stream source and the `adrv9001_tx` serializer input (`s_axis_*` of that core). It buffers 32-bit I/Q words in a small FIFO and primes the buffer before transmission starts. While running it presents a continuous-valid stream to the serializer, substituting idle data on underflow and counting those events. It also provides constant-idle and ramp test-pattern modes for bring-up of the LVDS link.

## Interface
- `FIFO_DEPTH`, 16: FIFO entries; power of 2, minimum 4.
- `PRIME_LEVEL`, 8: FIFO occupancy required before leaving PRIME in DMA mode; 1..FIFO_DEPTH.
- `IDLE_DATA`, 32'h00000000: word sent on underflow and in constant mode.
- `UFLOW_CNT_W`, 16: width of the underflow counter.

- `clk` in 1: single clock. Serializer `clk` domain.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: level. 1 = transmit, 0 = stop and flush.
- `mode` in 2: 0 = DMA, 1 = constant IDLE_DATA, 2 = ramp, 3 = same as 1. Latched on the IDLE->PRIME transition.
- `s_axis_tdata` in 32: upstream sample, {I[15:0], Q[15:0]}.
- `s_axis_tvalid` in 1: upstream valid.
- `s_axis_tready` out 1: FIFO can accept.
- `m_axis_tdata` out 32: sample to the serializer.
- `m_axis_tvalid` out 1: output valid.
- `m_axis_tready` in 1: serializer accepts.
- `active` out 1: state == RUN.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current occupancy.
- `underflow` out 1: one-cycle pulse per underflowed output handshake.
- `underflow_cnt` out UFLOW_CNT_W: saturating underflow count.

## Operation
- States: IDLE, PRIME, RUN.
- **IDLE**
  - FIFO is held empty; `s_axis_tready` = 0; `m_axis_tvalid` = 0.
  - `enable` = 1 -> PRIME. On this transition, latch `mode` and clear `underflow_cnt`.
- **PRIME**
  - `s_axis_tready` = (`fifo_level` < FIFO_DEPTH).
  - Leave PRIME when (mode == 0 and `fifo_level` >= PRIME_LEVEL), or immediately (one cycle) when mode != 0.
  - On leaving, load the output register with the first word: the FIFO head (popped), IDLE_DATA, or ramp word 0. Next state RUN.
- **RUN**
  - `m_axis_tvalid` = 1. `s_axis_tready` behaves as in PRIME; in modes 1/2, FIFO input is still accepted but ignored (dropped).
  - On each handshake (`m_axis_tvalid` & `m_axis_tready`), load the next word:
    - mode 0, FIFO non-empty: pop the FIFO head.
    - mode 0, FIFO empty: load IDLE_DATA, pulse `underflow`, increment `underflow_cnt` (saturating at all-ones).
    - mode 1/3: IDLE_DATA.
    - mode 2: r = r+1, word = {r[15:0], ~r[15:0]}. r resets to 0 on PRIME exit.
  - Without a handshake, `m_axis_tdata` holds its value.
- **Stop:** `enable` = 0 in PRIME or RUN -> IDLE on the next edge. The pending output word is discarded and the FIFO is flushed (level 0 the following cycle). The downstream serializer is a continuous consumer, so dropping tvalid without a handshake is permitted.
- **FIFO**
  - Push and pop in the same cycle leave the level unchanged.
  - `s_axis_tready` is derived from the registered level, so a full FIFO refuses input even in a pop cycle.
  - Pointers wrap modulo FIFO_DEPTH; level counts 0..FIFO_DEPTH.
- **Reset:** `rst` = 1 at any time forces IDLE and clears FIFO, `m_axis_tdata` (0), `m_axis_tvalid` (0), `s_axis_tready` (0), `active` (0), `underflow` (0), `underflow_cnt` (0), r (0).

## Timing
- Input to FIFO: a word accepted at edge N is visible in `fifo_level` at N+1.
- Priming latency, DMA mode: an empty FIFO fed one word per cycle reaches PRIME_LEVEL after PRIME_LEVEL cycles. RUN and `m_axis_tvalid` = 1 follow one edge after that; first word = first word accepted.
- Priming latency, modes 1/2: `enable` high at edge N -> PRIME at N+1 -> RUN/tvalid at N+2.
- Output is fully registered. With `m_axis_tready` high every cycle, throughput is 1 word/clk.
- `underflow` is asserted in the cycle after the handshake that caused it, aligned with the IDLE_DATA word appearing on `m_axis_tdata`.
- Stop latency: `enable` low sampled at edge N -> `m_axis_tvalid` = 0 and `active` = 0 after N.

## Test plan
1. **Reset mid-RUN:** assert `rst` for 1 cycle with FIFO at 5 -> next cycle all outputs 0, `fifo_level` = 0, state IDLE.
2. **DMA priming:** mode 0, `enable` = 1; push 12'h.. words 32'h12345678, 32'haa015502, 32'h32324545, ... at 1/clk with `m_axis_tready` = 1 -> tvalid rises after the 8th push; output order is identical to input with no gaps while input keeps pace.
3. **Underflow:** mode 0 RUN, stop input, `m_axis_tready` = 1 -> after the FIFO drains, `m_axis_tdata` = 0 each cycle, `underflow` pulses every cycle, `underflow_cnt` increments. Force the count to 16'hFFFE: it stays at 16'hFFFF.
4. **Full FIFO:** `m_axis_tready` = 0 in RUN, continuous input -> `fifo_level` stops at 16 and `s_axis_tready` = 0; no words lost or duplicated after `m_axis_tready` returns.
5. **Ramp:** mode 2 -> words 32'h0000FFFF, 32'h0001FFFE, 32'h0002FFFD; hold with `m_axis_tready` = 0 for 3 cycles -> word stable; counter wraps from 32'hFFFF0000 to 32'h0000FFFF.
6. **Stop/restart:** `enable` low in RUN with 6 words buffered -> tvalid 0 next cycle, level 0. Re-enable in mode 1 -> 32'h00000000 stream, `underflow_cnt` cleared and never incremented.
